// File: rtl/key_schedule_ctrl_pkg.sv
// Shared AES key-schedule types and byte/word helpers (S-box, xtime, SubWord).
package key_schedule_ctrl_pkg;
  localparam int AES128_NK = 4;
  localparam int AES128_NR = 10;
  localparam int AES192_NK = 6;
  localparam int AES192_NR = 12;
  localparam int AES256_NK = 8;
  localparam int AES256_NR = 14;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] rkey_t;

  // Which transform the shared step unit applies to the previous word.
  typedef enum logic [1:0] {WK_PLAIN, WK_ROT, WK_SUB} wk_class_t;

  // Row-major FIPS-197 table; entry 0x00 sits in the top byte, hence the ~x index.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[~x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic word_t subword(input word_t w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Control/read bus of the key-schedule engine; key word 0 occupies the top 32 bits.
interface key_schedule_ctrl_if #(
  parameter int NK = 4,
  parameter int NR = 10
);
  localparam int RW = $clog2(NR + 1);

  logic            start;
  logic [NK*32-1:0] key;
  logic            busy;
  logic            key_ready;
  logic [NR:0]     rk_avail;
  logic            rd_en;
  logic [RW-1:0]   rd_round;
  logic            rd_valid;
  logic [127:0]    rd_data;
  logic            rd_err;

  modport master (
    output start, key, rd_en, rd_round,
    input  busy, key_ready, rk_avail, rd_valid, rd_data, rd_err
  );
  modport slave (
    input  start, key, rd_en, rd_round,
    output busy, key_ready, rk_avail, rd_valid, rd_data, rd_err
  );
endinterface

// File: rtl/key_schedule_ctrl_key_word_step.sv
// One AES key-expansion word step: w[i] = w[i-NK] ^ f(w[i-1]).
module key_word_step
  import key_schedule_ctrl_pkg::*;
(
  input  word_t     prev,
  input  word_t     back,
  input  wk_class_t cls,
  input  logic [7:0] rcon,
  output word_t     nxt
);
  word_t temp;

  always_comb begin
    temp = prev;
    case (cls)
      WK_ROT:  temp = subword({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0};
      WK_SUB:  temp = subword(prev);
      default: temp = prev;
    endcase
    nxt = back ^ temp;
  end
endmodule

// File: rtl/key_schedule_ctrl.sv
// Sequential AES key expansion: one word per clock into a round-key store, with
// per-round availability so cipher rounds can begin before expansion finishes.
module key_schedule_ctrl
  import key_schedule_ctrl_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic clk,
  input  logic rst,
  key_schedule_ctrl_if.slave bus
);
  localparam int NW = 4 * (NR + 1);
  localparam int IW = $clog2(NW);
  localparam int KW = (NK > 1) ? $clog2(NK) : 1;
  localparam int RW = $clog2(NR + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;

  function automatic logic [NR:0] key_rounds();
    logic [NR:0] m;
    m = '0;
    for (int r = 0; r <= NR; r++) m[r] = (4 * r + 3 < NK);
    return m;
  endfunction
  localparam logic [NR:0] KEY_AVAIL = key_rounds();

  logic [1:0]         state;
  logic               busy_q, ready_q;
  logic [NR:0]        avail;
  logic [IW-1:0]      widx;
  logic [KW-1:0]      kpos;    // widx % NK, tracked incrementally
  logic [7:0]         rcon;
  word_t [NK-1:0]     win;     // win[0] = w[i-NK], win[NK-1] = w[i-1]
  word_t [NK-1:0]     keyw;
  word_t              store [NW];
  word_t              nxt;
  wk_class_t          cls;
  logic               ld;
  logic [RW-1:0]      wr_round;

  always_comb begin
    for (int j = 0; j < NK; j++) keyw[j] = bus.key[NK*32-1-32*j -: 32];
    ld       = (state == S_IDLE || state == S_READY) && bus.start;
    wr_round = RW'(widx >> 2);
    if (kpos == '0)                       cls = WK_ROT;
    else if (NK > 6 && int'(kpos) == 4)   cls = WK_SUB;
    else                                  cls = WK_PLAIN;
  end

  key_word_step u_step (
    .prev (win[NK-1]),
    .back (win[0]),
    .cls  (cls),
    .rcon (rcon),
    .nxt  (nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      avail   <= '0;
      widx    <= '0;
      kpos    <= '0;
      rcon    <= '0;
      win     <= '0;
    end else begin
      case (state)
        S_IDLE, S_READY: if (bus.start) begin
          state   <= S_EXPAND;
          busy_q  <= 1'b1;
          ready_q <= 1'b0;
          avail   <= KEY_AVAIL;
          win     <= keyw;
          widx    <= IW'(NK);
          kpos    <= '0;
          rcon    <= 8'h01;
        end
        S_EXPAND: begin
          win  <= {nxt, win[NK-1:1]};
          widx <= widx + IW'(1);
          kpos <= (kpos == KW'(NK - 1)) ? '0 : kpos + KW'(1);
          if (kpos == '0) rcon <= xtime(rcon);
          if (widx[1:0] == 2'b11) avail[wr_round] <= 1'b1;
          if (widx == IW'(NW - 1)) begin
            state   <= S_READY;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Store is not reset; avail gates every read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (ld) begin
        for (int j = 0; j < NK; j++) store[j] <= keyw[j];
      end else if (state == S_EXPAND) begin
        store[widx] <= nxt;
      end
    end
  end

  logic          rd_hit;
  logic [IW-1:0] rbase;
  logic          rd_valid_q, rd_err_q;
  rkey_t         rd_data_q;

  // Hit uses pre-edge avail, so a same-cycle write or start is not forwarded.
  always_comb begin
    rbase  = IW'({bus.rd_round, 2'b00});
    rd_hit = (bus.rd_round <= RW'(NR)) && avail[bus.rd_round];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        if (rd_hit) begin
          rd_data_q <= {store[rbase], store[rbase + IW'(1)],
                        store[rbase + IW'(2)], store[rbase + IW'(3)]};
          rd_err_q  <= 1'b0;
        end else begin
          rd_data_q <= '0;
          rd_err_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.key_ready = ready_q;
  assign bus.rk_avail  = avail;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_err    = rd_err_q;
  assign bus.rd_data   = rd_data_q;
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Scoreboard bench for key_schedule_ctrl: AES-128 and AES-256 instances checked
// against a GF(2^8)-arithmetic key-expansion model.
module tb_key_schedule_ctrl;
  typedef logic [59:0][31:0] warr_t;
  typedef struct packed { logic err; logic [127:0] data; } rsp_t;

  localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_schedule_ctrl_if #(.NK(4), .NR(10)) ia ();
  key_schedule_ctrl_if #(.NK(8), .NR(14)) ib ();

  key_schedule_ctrl #(.NK(4), .NR(10)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  key_schedule_ctrl #(.NK(8), .NR(14)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

  int checks = 0;
  int errors = 0;
  rsp_t qa[$], qb[$];
  logic [7:0] sb [256];
  warr_t wa, wb;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // FIPS-197 KeyExpansion; key word 0 is taken from the top of k.
  function automatic warr_t expand(input logic [255:0] k, input int nk, input int nr);
    warr_t w;
    logic [31:0] t;
    logic [7:0] rc;
    w = '0;
    for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int j = 1; j < i / nk; j++) rc = gmul(rc, 8'h02);
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return w;
  endfunction

  function automatic logic [127:0] rk(input warr_t w, input int r);
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: pop on every response, otherwise rd_data must hold its last value.
  logic [127:0] last_a, last_b;
  rsp_t pa, pb;
  always @(negedge clk) begin
    if (ia.rd_valid === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected_valid", 128'(ia.rd_valid), 128'd0);
      else begin
        pa = qa.pop_front();
        chk("a_rd_err", 128'(ia.rd_err), 128'(pa.err));
        chk("a_rd_data", ia.rd_data, pa.data);
        last_a = pa.data;
      end
    end else if (rst) last_a = '0;
    else chk("a_rd_hold", ia.rd_data, last_a);
  end
  always @(negedge clk) begin
    if (ib.rd_valid === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_valid", 128'(ib.rd_valid), 128'd0);
      else begin
        pb = qb.pop_front();
        chk("b_rd_err", 128'(ib.rd_err), 128'(pb.err));
        chk("b_rd_data", ib.rd_data, pb.data);
        last_b = pb.data;
      end
    end else if (rst) last_b = '0;
    else chk("b_rd_hold", ib.rd_data, last_b);
  end

  task automatic rd_a(input int r, input logic err, input logic [127:0] d);
    ia.rd_en = 1'b1; ia.rd_round = 4'(r);
    qa.push_back({err, d});
    tick();
    ia.rd_en = 1'b0;
  endtask

  task automatic rd_b(input int r, input logic err, input logic [127:0] d);
    ib.rd_en = 1'b1; ib.rd_round = 4'(r);
    qb.push_back({err, d});
    tick();
    ib.rd_en = 1'b0;
  endtask

  // mode 1: poll round 1 every cycle; mode 2: random reads. Edge e counts from the start edge.
  task automatic run_a(input logic [127:0] k, input int mode, input int bogus_at,
                       input int rst_at, input bit rd_at_start);
    int r;
    bit ok;
    logic [10:0] av;
    ia.start = 1'b1; ia.key = k;
    if (rd_at_start) begin
      ia.rd_en = 1'b1; ia.rd_round = 4'd10;
      qa.push_back({1'b0, rk(wa, 10)});
    end
    tick();
    ia.start = 1'b0; ia.rd_en = 1'b0;
    wa = expand({k, 128'h0}, 4, 10);
    for (int e = 1; e <= 42; e++) begin
      ia.start = 1'b0; ia.rd_en = 1'b0;
      if (mode == 1) begin ia.rd_en = 1'b1; ia.rd_round = 4'd1; end
      else if (mode == 2) begin
        ia.rd_en = 1'($urandom_range(0, 1));
        ia.rd_round = 4'($urandom_range(0, 15));
      end
      if (e == bogus_at) begin ia.start = 1'b1; ia.key = '0; end
      if (e == rst_at) begin rst = 1'b1; ia.rd_en = 1'b0; end
      if (ia.rd_en) begin
        r = int'(ia.rd_round);
        ok = (r <= 10) && (r == 0 || 4 * r < e);
        qa.push_back(ok ? {1'b0, rk(wa, r)} : {1'b1, 128'h0});
      end
      tick();
      if (e == rst_at) begin
        chk("a_rst_busy", 128'(ia.busy), 128'd0);
        chk("a_rst_key_ready", 128'(ia.key_ready), 128'd0);
        chk("a_rst_rk_avail", 128'(ia.rk_avail), 128'd0);
        rst = 1'b0;
        ia.start = 1'b0;
        return;
      end
      for (int q = 0; q <= 10; q++) av[q] = (q == 0) || (4 * q <= e);
      chk("a_busy", 128'(ia.busy), 128'(e < 40));
      chk("a_key_ready", 128'(ia.key_ready), 128'(e >= 40));
      chk("a_rk_avail", 128'(ia.rk_avail), 128'(av));
    end
    ia.start = 1'b0; ia.rd_en = 1'b0;
  endtask

  initial begin
    int lat;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int j = 0; j < 254; j++) inv = gmul(inv, 8'(x));
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    rst = 1'b1;
    ia.start = 1'b0; ia.key = '0; ia.rd_en = 1'b0; ia.rd_round = '0;
    ib.start = 1'b0; ib.key = '0; ib.rd_en = 1'b0; ib.rd_round = '0;
    repeat (3) tick();
    chk("rst_busy", 128'(ia.busy), 128'd0);
    chk("rst_key_ready", 128'(ia.key_ready), 128'd0);
    chk("rst_rk_avail", 128'(ia.rk_avail), 128'd0);
    chk("rst_rd_valid", 128'(ia.rd_valid), 128'd0);
    chk("rst_rd_err", 128'(ia.rd_err), 128'd0);
    chk("rst_rd_data", ia.rd_data, 128'd0);
    chk("rst_b_rk_avail", 128'(ib.rk_avail), 128'd0);
    rst = 1'b0;
    tick();

    // FIPS AES-128 with round-1 polling during expansion
    run_a(K1, 1, 0, 0, 1'b0);
    rd_a(1, 1'b0, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_a(10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd_a(11, 1'b1, 128'h0);
    rd_a(15, 1'b1, 128'h0);

    // Random reads plus an ignored start mid-expansion
    run_a(K1, 2, 15, 0, 1'b0);
    for (int n = 0; n < 20; n++) begin
      int r;
      r = $urandom_range(0, 12);
      rd_a(r, r > 10, (r > 10) ? 128'h0 : rk(wa, r));
    end
    rd_a(10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Rekey from READY with a same-cycle read of old round 10
    run_a(128'h0, 2, 0, 0, 1'b1);
    rd_a(10, 1'b0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Abort mid-expansion, then a clean run
    run_a(K1, 2, 0, 10, 1'b0);
    tick();
    rd_a(0, 1'b1, 128'h0);
    run_a(K1, 0, 0, 0, 1'b0);
    rd_a(1, 1'b0, 128'ha0fafe1788542cb123a339392a6c7605);
    rd_a(10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // AES-256
    wb = expand(K256, 8, 14);
    ib.start = 1'b1; ib.key = K256;
    tick();
    ib.start = 1'b0;
    lat = 0;
    while (ib.key_ready !== 1'b1 && lat < 200) begin
      tick();
      lat++;
    end
    chk("b_latency", 128'(lat), 128'd52);
    chk("b_busy_done", 128'(ib.busy), 128'd0);
    chk("b_w8", 128'(wb[8]), 128'(32'h9ba35411));
    for (int r = 0; r <= 14; r++) rd_b(r, 1'b0, rk(wb, r));
    rd_b(14, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e);
    rd_b(15, 1'b1, 128'h0);

    repeat (3) tick();
    chk("a_queue_drained", 128'(qa.size()), 128'd0);
    chk("b_queue_drained", 128'(qb.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
